// File: rtl/loader_pkg.sv
// Shared state encoding and framing constants for the instruction-memory loader.
// The optional trailing checksum byte is enabled by defining LOADER_CHECKSUM_EN.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_HI,
        ST_HDR_LO,
        ST_BYTES,
        ST_WRITE,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int CSUM_W         = 8;

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// Big-endian word assembler: shifts stream bytes in MSB-first and flags when
// the next accepted byte completes a word.
module word_assembler
    import loader_pkg::*;
(
    input  logic                        clk,
    input  logic                        clear,
    input  logic                        load,
    input  logic [7:0]                  byte_in,
    output logic [8*BYTES_PER_WORD-1:0] word,
    output logic                        full
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] count;

    // NOTE: clear doubles as the reset path, so the word and counter are
    // synchronously cleared together with the rest of the loader.
    always_ff @(posedge clk) begin
        if (clear) begin
            word  <= '0;
            count <= '0;
        end else if (load) begin
            word  <= {word[8*BYTES_PER_WORD-9:0], byte_in};
            count <= count + CNT_W'(1);
        end
    end

    assign full = (count == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-stream program loader for the instruction-memory write port; holds the
// core until the image is complete. Optional checksum: LOADER_CHECKSUM_EN.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [7:0]        ByteIn,
    input  logic              ByteValid,
    output logic              ByteReady,
    output logic [31:0]       WriteData,
    output logic              WriteEnable,
    output logic [ADDR_W-1:0] WriteAddr,
    output logic              CoreHold,
    output logic              Done,
    output logic              Error
);

    localparam int N_W   = 8 * HDR_BYTES;
    localparam int CMP_W = N_W + 1;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t END_STATE = ST_CHK;
`else
    localparam state_t END_STATE = ST_DONE;
`endif

    state_t            state, next_state;
    logic [7:0]        hdr_hi;
    logic [N_W-1:0]    count_n;
    logic [N_W-1:0]    hdr_n;
    logic [ADDR_W:0]   index;
    logic [31:0]       asm_word;
    logic              asm_full;
    logic              asm_load;
    logic              asm_clear;
    logic              byte_fire;
    logic              start_ok;
    logic              too_big;
    logic              last_word;

`ifdef LOADER_CHECKSUM_EN
    logic [CSUM_W-1:0] csum;
`endif

    assign byte_fire = ByteValid && ByteReady;
    assign start_ok  = Start && (state inside {ST_IDLE, ST_DONE, ST_ERR});
    assign hdr_n     = {hdr_hi, ByteIn};
    assign too_big   = CMP_W'(hdr_n) > (CMP_W'(1) << ADDR_W);
    assign last_word = (CMP_W'(index) + CMP_W'(1)) == CMP_W'(count_n);
    assign asm_load  = byte_fire && (state == ST_BYTES);
    assign asm_clear = Reset || start_ok;

    word_assembler u_asm (
        .clk     (Clk),
        .clear   (asm_clear),
        .load    (asm_load),
        .byte_in (ByteIn),
        .word    (asm_word),
        .full    (asm_full)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= ST_IDLE;
            hdr_hi  <= '0;
            count_n <= '0;
            index   <= '0;
        end else begin
            state <= next_state;
            if (state == ST_HDR_HI && byte_fire)
                hdr_hi <= ByteIn;
            if (state == ST_HDR_LO && byte_fire)
                count_n <= hdr_n;
            if (start_ok)
                index <= '0;
            else if (state == ST_WRITE)
                index <= index + (ADDR_W+1)'(1);
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge Clk) begin
        if (Reset || start_ok)
            csum <= '0;
        else if (asm_load)
            csum <= csum ^ ByteIn;
    end
`endif

    // NOTE: next_state takes its default before the case so no path through
    // this block leaves it unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (Start)
                    next_state = ST_HDR_HI;
            end
            ST_HDR_HI: begin
                if (byte_fire)
                    next_state = ST_HDR_LO;
            end
            ST_HDR_LO: begin
                if (byte_fire) begin
                    if (hdr_n == '0)
                        next_state = END_STATE;
                    else if (too_big)
                        next_state = ST_ERR;
                    else
                        next_state = ST_BYTES;
                end
            end
            ST_BYTES: begin
                if (byte_fire && asm_full)
                    next_state = ST_WRITE;
            end
            ST_WRITE: begin
                next_state = last_word ? END_STATE : ST_BYTES;
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (byte_fire)
                    next_state = (ByteIn == csum) ? ST_DONE : ST_ERR;
            end
`endif
            default: next_state = ST_IDLE;
        endcase
    end

    // Every output is a state decode or a register; ByteValid never reaches ByteReady.
    assign ByteReady   = state inside {ST_HDR_HI, ST_HDR_LO, ST_BYTES, ST_CHK};
    assign CoreHold    = !(state inside {ST_IDLE, ST_DONE});
    assign WriteEnable = (state == ST_WRITE);
    assign Done        = (state == ST_DONE);
    assign Error       = (state == ST_ERR);
    assign WriteData   = asm_word;
    assign WriteAddr   = index[ADDR_W-1:0];

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: vector table, reset/stall corner
// cases and randomized images against a byte-level reference model.
module tb_instr_mem_loader;

    localparam int ADDR_W = 8;
`ifdef LOADER_CHECKSUM_EN
    localparam int CSUM = 1;
`else
    localparam int CSUM = 0;
`endif

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Start;
    logic [7:0]        ByteIn;
    logic              ByteValid;
    logic              ByteReady;
    logic [31:0]       WriteData;
    logic              WriteEnable;
    logic [ADDR_W-1:0] WriteAddr;
    logic              CoreHold;
    logic              Done;
    logic              Error;

    always #5 Clk = ~Clk;

    instr_mem_loader #(.ADDR_W(ADDR_W)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .ByteIn      (ByteIn),
        .ByteValid   (ByteValid),
        .ByteReady   (ByteReady),
        .WriteData   (WriteData),
        .WriteEnable (WriteEnable),
        .WriteAddr   (WriteAddr),
        .CoreHold    (CoreHold),
        .Done        (Done),
        .Error       (Error)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Write monitor, sampled on the falling edge.
    logic [31:0] wr_data_q[$];
    int          wr_addr_q[$];

    always @(negedge Clk) begin
        if (WriteEnable === 1'b1) begin
            wr_data_q.push_back(WriteData);
            wr_addr_q.push_back(int'(WriteAddr));
        end
    end

    // Reference model: parse the image by the framing rules directly.
    logic [31:0] m_data[$];
    bit          m_done;
    bit          m_err;

    task automatic model(input logic [7:0] img[$]);
        int n;
        int pos;
        logic [7:0] x;
        m_data.delete();
        m_done = 0;
        m_err  = 0;
        n = int'({img[0], img[1]});
        if (n > (1 << ADDR_W)) begin
            m_err = 1;
            return;
        end
        x   = 8'h00;
        pos = 2;
        for (int w = 0; w < n; w++) begin
            m_data.push_back({img[pos], img[pos+1], img[pos+2], img[pos+3]});
            x = x ^ img[pos] ^ img[pos+1] ^ img[pos+2] ^ img[pos+3];
            pos += 4;
        end
        if (CSUM == 1) begin
            if (img[pos] == x) m_done = 1;
            else               m_err  = 1;
        end else begin
            m_done = 1;
        end
    endtask

    task automatic compare_writes(input string name);
        check({name, " write_count"}, wr_data_q.size(), m_data.size());
        for (int j = 0; j < wr_data_q.size() && j < m_data.size(); j++) begin
            check($sformatf("%s addr[%0d]", name, j), wr_addr_q[j], j);
            check($sformatf("%s data[%0d]", name, j), wr_data_q[j], m_data[j]);
        end
    endtask

    // mode: 0 = ByteValid held high, 1 = toggling, 2 = random stalls.
    task automatic run_image(input string name, input logic [7:0] img[$], input int mode,
                             input bit glitch, input int exp_cycles);
        int i;
        int elapsed;
        int budget;
        bit v;
        bit r;
        i = 0;
        budget = 20 * img.size() + 50;
        wr_data_q.delete();
        wr_addr_q.delete();
        @(negedge Clk);
        Start = 1'b1;
        ByteValid = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        elapsed = 0;
        check({name, " hold_after_start"}, CoreHold, 1);
        check({name, " done_drops"}, Done, 0);
        check({name, " ready_hdr"}, ByteReady, 1);
        while (!(Done || Error) && elapsed < budget) begin
            Start = glitch && (elapsed == 5);
            case (mode)
                0:       v = 1'b1;
                1:       v = (elapsed % 2) == 0;
                default: v = $urandom_range(0, 1) == 1;
            endcase
            v = v && (i < img.size());
            ByteValid = v;
            ByteIn = v ? img[i] : 8'h00;
            r = ByteReady;
            @(negedge Clk);
            elapsed++;
            if (v && r) i++;
        end
        Start = 1'b0;
        ByteValid = 1'b0;
        if (exp_cycles >= 0)
            check({name, " cycles_to_done"}, elapsed, exp_cycles);
    endtask

    typedef struct {
        logic [127:0] img;
        int           len;
        int           mode;
        bit           exp_done;
        bit           exp_err;
        int           exp_writes;
        logic [31:0]  exp_last;
        int           exp_cycles;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [127:0] img, int len, int mode, bit d, bit e,
                                int nw, logic [31:0] last, int cyc);
        vec_t t;
        t.img = img; t.len = len; t.mode = mode; t.exp_done = d; t.exp_err = e;
        t.exp_writes = nw; t.exp_last = last; t.exp_cycles = cyc;
        return t;
    endfunction

    task automatic check_outputs_zero(input string name);
        check({name, " ByteReady"}, ByteReady, 0);
        check({name, " WriteEnable"}, WriteEnable, 0);
        check({name, " WriteData"}, WriteData, 0);
        check({name, " WriteAddr"}, WriteAddr, 0);
        check({name, " CoreHold"}, CoreHold, 0);
        check({name, " Done"}, Done, 0);
        check({name, " Error"}, Error, 0);
    endtask

    initial begin
        logic [7:0]   img_q[$];
        logic [127:0] tmp;
        int           n;
        int           mode;
        int           exp_cyc;
        logic [7:0]   x;

        Reset = 1'b1;
        Start = 1'b0;
        ByteIn = 8'h00;
        ByteValid = 1'b0;
        repeat (2) @(negedge Clk);
        check_outputs_zero("reset");
        Reset = 1'b0;

`ifdef LOADER_CHECKSUM_EN
        vecs.push_back(mk(128'h0002_2008_0005_0109_5020_55, 11, 0, 1, 0, 2, 32'h01095020, 13));
        vecs.push_back(mk(128'h0002_2008_0005_0109_5020_55, 11, 1, 1, 0, 2, 32'h01095020, -1));
        vecs.push_back(mk(128'h0000_00, 3, 0, 1, 0, 0, 32'h0, 3));
        vecs.push_back(mk(128'h0101, 2, 0, 0, 1, 0, 32'h0, -1));
        vecs.push_back(mk(128'h0001_AABBCCDD_00, 7, 0, 1, 0, 1, 32'hAABBCCDD, 8));
        vecs.push_back(mk(128'h0001_AABBCCDD_01, 7, 0, 0, 1, 1, 32'hAABBCCDD, -1));
`else
        vecs.push_back(mk(128'h0002_2008_0005_0109_5020, 10, 0, 1, 0, 2, 32'h01095020, 12));
        vecs.push_back(mk(128'h0002_2008_0005_0109_5020, 10, 1, 1, 0, 2, 32'h01095020, -1));
        vecs.push_back(mk(128'h0000, 2, 0, 1, 0, 0, 32'h0, 2));
        vecs.push_back(mk(128'h0101, 2, 0, 0, 1, 0, 32'h0, -1));
        vecs.push_back(mk(128'h0001_AABBCCDD, 6, 0, 1, 0, 1, 32'hAABBCCDD, 7));
`endif

        for (int k = 0; k < vecs.size(); k++) begin
            string nm;
            nm = $sformatf("vec%0d", k);
            img_q.delete();
            for (int b = 0; b < vecs[k].len; b++) begin
                tmp = vecs[k].img >> (8 * (vecs[k].len - 1 - b));
                img_q.push_back(tmp[7:0]);
            end
            model(img_q);
            run_image(nm, img_q, vecs[k].mode, 1'b0, vecs[k].exp_cycles);
            check({nm, " Done"}, Done, vecs[k].exp_done);
            check({nm, " Error"}, Error, vecs[k].exp_err);
            check({nm, " CoreHold"}, CoreHold, vecs[k].exp_err);
            check({nm, " writes"}, wr_data_q.size(), vecs[k].exp_writes);
            if (vecs[k].exp_writes > 0 && wr_data_q.size() > 0) begin
                check({nm, " last_data"}, wr_data_q[wr_data_q.size()-1], vecs[k].exp_last);
                check({nm, " first_addr"}, wr_addr_q[0], 0);
            end
            compare_writes(nm);
        end

        // Reset two payload bytes into a load: partial word is dropped.
        wr_data_q.delete();
        wr_addr_q.delete();
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        img_q = '{8'h00, 8'h02, 8'h20, 8'h08};
        for (int b = 0; b < 4; b++) begin
            ByteValid = 1'b1;
            ByteIn = img_q[b];
            @(negedge Clk);
        end
        check("midload CoreHold", CoreHold, 1);
        Reset = 1'b1;
        ByteValid = 1'b0;
        @(negedge Clk);
        check_outputs_zero("midload_reset");
        Reset = 1'b0;
        ByteValid = 1'b1;
        ByteIn = 8'h05;
        repeat (12) @(negedge Clk);
        ByteValid = 1'b0;
        check("midload no_write", wr_data_q.size(), 0);
        check("midload idle_ready", ByteReady, 0);
        check("midload idle_done", Done, 0);

        // Randomized images, including empty and full-memory loads.
        for (int k = 0; k < 8; k++) begin
            string nm;
            nm = $sformatf("rand%0d", k);
            n = (k == 7) ? (1 << ADDR_W) : (k == 6) ? 0 : int'($urandom_range(1, 6));
            mode = (k == 7 || k == 1) ? 0 : k % 3;
            img_q.delete();
            img_q.push_back(8'(n >> 8));
            img_q.push_back(8'(n));
            x = 8'h00;
            for (int b = 0; b < 4 * n; b++) begin
                logic [7:0] rb;
                rb = 8'($urandom);
                x ^= rb;
                img_q.push_back(rb);
            end
            if (CSUM == 1)
                img_q.push_back((k == 3) ? ~x : x);
            model(img_q);
            exp_cyc = (mode == 0 && m_done) ? 2 + 5 * n + CSUM : -1;
            run_image(nm, img_q, mode, k == 1, exp_cyc);
            check({nm, " Done"}, Done, m_done);
            check({nm, " Error"}, Error, m_err);
            compare_writes(nm);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Program loader that drives the instruction-memory write port (WriteData/WriteEnable) of the pipelined MIPS core from a byte stream. It parses a 2-byte word-count header and assembles big-endian 32-bit instruction words. It writes each word to sequential word addresses starting at 0. CoreHold keeps the core stalled until the image is complete. It sits between a byte source (UART receiver or testbench) and the core's fetch-stage write port.

## Interface
- ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high
- Start  in  1  one-cycle pulse; begins a load (accepted in IDLE, DONE, ERR only)
- ByteIn  in  8  stream byte
- ByteValid  in  1  ByteIn is valid
- ByteReady  out  1  loader accepts a byte this cycle
- WriteData  out  32  instruction word to memory
- WriteEnable  out  1  one-cycle write strobe
- WriteAddr  out  ADDR_W  word address of WriteData
- CoreHold  out  1  stall/hold request to the core
- Done  out  1  image loaded successfully (level)
- Error  out  1  load aborted (level)

## Operation
- Byte transfer occurs on a rising edge with ByteValid && ByteReady. ByteReady=1 only in HDR_HI, HDR_LO, BYTES, and CHK.
- States: IDLE, HDR_HI, HDR_LO, BYTES, WRITE, CHK (macro only), DONE, ERR.
- IDLE: CoreHold=0. Start -> HDR_HI; clear word index, byte count, and checksum.
- HDR_HI/HDR_LO: capture the count N[15:8], then N[7:0].
  - From HDR_LO: N==0 -> DONE (or CHK).
  - N > 2^ADDR_W -> ERR.
  - Otherwise -> BYTES.
- BYTES: shift each byte in MSB-first (`word = {word[23:0], ByteIn}`). Byte count runs 0..3. The 4th byte -> WRITE.
- WRITE: WriteEnable=1 for exactly one cycle, with WriteAddr = word index and WriteData = assembled word. ByteReady=0.
  - Index increments.
  - If index+1 == N -> DONE (or CHK); else -> BYTES.
- DONE: Done=1, CoreHold=0. Start -> HDR_HI (reload, Done drops).
- ERR: Error=1, CoreHold=1. Exit via Start (-> HDR_HI) or Reset.
- CoreHold=1 in HDR_HI, HDR_LO, BYTES, WRITE, CHK, ERR.
- Start outside IDLE/DONE/ERR is ignored.
- Word index is ADDR_W+1 bits wide. N == 2^ADDR_W fills memory exactly; WriteAddr does not wrap.

## Timing
- Reset: state=IDLE. WriteData=0, WriteAddr=0, WriteEnable=0, ByteReady=0, CoreHold=0, Done=0, Error=0.
- Reset mid-load: IDLE on the next edge. The partial word is discarded and no write is issued.
- All outputs are registered or decoded from state, with no combinational path from ByteValid to ByteReady.
- WriteEnable rises the cycle after the 4th byte of a word is accepted.
- Minimum cycles from the Start edge to Done=1: 2 + 5N (+1 with checksum), for a source with ByteValid held high.
- Source stalls (ByteValid=0) hold state indefinitely. There is no timeout.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After the last word (or after HDR_LO when N==0), enter CHK and accept one byte.
  - That byte must equal the XOR of all payload bytes (header excluded). Equal -> DONE; mismatch -> ERR.
  - Words already written remain in memory.
- Undefined: no CHK state and no trailing byte; the final WRITE (or HDR_LO with N==0) goes directly to DONE.

## Structure
- Package loader_pkg holds:
  - the state enum;
  - constants HDR_BYTES=2 and BYTES_PER_WORD=4;
  - the checksum width of 8.
- Sub-module word_assembler contains the shift register and the 2-bit byte counter. It has inputs load/clear and outputs word and full. It is used by the top-level FSM.

## Test plan
- Reset, then Start, then bytes 00 02 | 20 08 00 05 | 01 09 50 20:
  - WriteEnable pulses twice: (addr 0, 0x20080005), then (addr 1, 0x01095020).
  - Then Done=1 and CoreHold=0.
- Start with header 00 00: no WriteEnable, Done=1. With the macro, Done follows checksum byte 00.
- ADDR_W=8, header 01 01 (257): ERR, Error=1, CoreHold=1, no write.
- Same image as the first test with ByteValid toggling 1/0 every cycle: identical writes, with the Done cycle delayed accordingly.
- Reset asserted after 2 payload bytes: next cycle IDLE, all outputs 0, no WriteEnable afterwards.
- Macro defined: N=1 with word AA BB CC DD, checksum 00 -> Done. Checksum 01 -> Error, with one write of 0xAABBCCDD at addr 0.
